disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4; number of multiplexed 7-segment digits (2..8).
REQ-002 Parameter REFRESH_MAX, default 480000; each digit slot lasts REFRESH_MAX+1 cycles.
REQ-003 Parameter BLANK_CYCLES, default 16; anode-off guard at the start of each slot, 1 <= BLANK_CYCLES <= REFRESH_MAX.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 enable  in  1  scan enable; low blanks the display.
REQ-007 value_in  in  4*NUM_DIGITS  hex value to display; nibble k drives digit k, digit 0 rightmost.
REQ-008 value_valid  in  1  value_in offered.
REQ-009 value_ready  out  1  controller can accept a value.
REQ-010 blank_zeros  in  1  leading-zero suppression enable.
REQ-011 an  out  NUM_DIGITS  anode selects, active-low, at most one low.
REQ-012 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 dp  out  1  decimal point, active-low, held 1.
REQ-014 frame_done  out  1  one-cycle pulse at frame wrap.

Function
REQ-015 Outputs shall be registered; an, seg and frame_done change only on clock edges.
REQ-016 The FSM shall have states IDLE, BLANK and SHOW.
REQ-017 IDLE: an all 1, seg 7'h7F, slot counter 0, digit index 0; enable=1 moves to BLANK next cycle.
REQ-018 Slot counter shall count 0..REFRESH_MAX and wrap to 0; it is held at 0 in IDLE.
REQ-019 BLANK: an all 1; leave for SHOW when the counter reaches BLANK_CYCLES-1.
REQ-020 SHOW: an[idx]=0, seg=decode(nibble idx); leave for BLANK when the counter reaches REFRESH_MAX.
REQ-021 On leaving SHOW, idx shall increment, wrapping NUM_DIGITS-1 -> 0.
REQ-022 frame_done shall pulse for exactly one cycle on the wrap to 0.
REQ-023 enable=0 in any state shall force IDLE on the next edge, clearing counter and idx; pending data shall be kept.
REQ-024 value_ready shall equal NOT pending_valid.
REQ-025 Transfer: value_valid AND value_ready captures value_in into pending and sets pending_valid.
REQ-026 Pending shall move to the display register only at a frame wrap, or on any cycle while in IDLE; pending_valid then clears.
REQ-027 A capture coinciding with a frame wrap shall stay pending until the next wrap.
REQ-028 The display register shall never change mid-frame (no tearing).
REQ-029 Decode (hex to seg): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-030 With blank_zeros=1, digit k>0 shows seg 7'h7F if nibbles k..NUM_DIGITS-1 are all zero; digit 0 is always shown.
REQ-031 Counter width shall be $clog2(REFRESH_MAX+1); arithmetic shall be unsigned with no overflow beyond REFRESH_MAX.

Reset
REQ-032 rst=0 at an edge: state IDLE, counter 0, idx 0, display register 0, pending 0, pending_valid 0.
REQ-033 Reset values: an all 1, seg 7'h7F, dp 1, frame_done 0, value_ready 1 from the first post-reset cycle.
REQ-034 Reset mid-frame shall abort the scan with no frame_done pulse.

Structure
REQ-035 Package disp_pkg shall hold the state enum, SEG_BLANK=7'h7F and the hex segment table.
REQ-036 Sub-module hex_to_seg7 (combinational nibble-to-segment decoder) shall be instantiated once.

Verification (NUM_DIGITS=4, REFRESH_MAX=9, BLANK_CYCLES=2)
REQ-037 Reset then enable=1: an sequence 1111 x2 cycles, 1110 x8, repeating for 1101/1011/0111; frame_done pulses every 40 cycles.
REQ-038 Load 16'h12AF while in IDLE, then enable: seg digit0=0E, digit1=08, digit2=24, digit3=79.
REQ-039 Load 16'h0005 mid-frame: display changes only after the next frame_done; value_ready is 0 until then; a second value_valid is stalled.
REQ-040 blank_zeros=1 with 16'h0005: digits 3..1 seg=7F, digit0 seg=12; 16'h0000 shows only digit0=40.
REQ-041 Drop enable mid-SHOW: next cycle an=1111, seg=7F; re-enable restarts at digit 0 with a BLANK phase.
REQ-042 Assert rst=0 mid-frame with a value pending: all reset values appear next cycle, pending is lost, and no frame_done pulse occurs.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value (entry 0 is rightmost).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller with per-slot anode blanking,
// frame-synchronous value update and optional leading-zero suppression.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_MAX  = 480000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    blank_zeros,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int unsigned CW = $clog2(REFRESH_MAX + 1);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned DW = 4 * NUM_DIGITS;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         disp_q, pend_q;
  logic                  pend_valid_q;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_done_q;
  logic                  wrap;
  logic                  xfer;
  logic                  cap;
  logic [3:0]            nib;
  logic                  upper_nz;
  logic [6:0]            dec_seg;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BLANK_CYCLES - 1)) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == CW'(REFRESH_MAX)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IW'(NUM_DIGITS - 1)) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign xfer = pend_valid_q && ((state_q == ST_IDLE) || wrap);
  assign cap  = value_valid && !pend_valid_q;

  // Outputs are registered from next-state so an/seg line up with the state register.
  // disp_q is stable whenever the next state is SHOW, so it can be read directly.
  always_comb begin
    nib      = '0;
    upper_nz = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) == idx_d) nib = disp_q[4*k +: 4];
      if ((k >= 32'(idx_d)) && (disp_q[4*k +: 4] != 4'h0)) upper_nz = 1'b1;
    end
  end

  hex_to_seg7 u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (state_d == ST_SHOW) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = (blank_zeros && (idx_d != '0) && !upper_nz) ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= wrap;
      if (xfer) begin
        disp_q       <= pend_q;
        pend_valid_q <= 1'b0;
      end else if (cap) begin
        pend_q       <= value_in;
        pend_valid_q <= 1'b1;
      end
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = 1'b1;
  assign frame_done  = frame_done_q;
  assign value_ready = !pend_valid_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: per-cycle reference model plus directed literal checks.
module tb_disp_scan_ctrl;

  localparam int ND    = 4;
  localparam int RM    = 9;
  localparam int BC    = 2;
  localparam int SLOT  = RM + 1;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] value_in = '0;
  logic        value_valid = 1'b0;
  logic        blank_zeros = 1'b0;
  logic        value_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: scan position counted from the start of scanning.
  bit          m_started = 0;
  bit          m_run = 0;
  bit          m_fd = 0;
  bit          m_bz = 0;
  bit          m_pv = 0;
  int          m_pos = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;

  disp_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_MAX  (RM),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .blank_zeros (blank_zeros),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void expect_out(output logic [3:0] an_e, output logic [6:0] seg_e);
    int          off;
    int          slot;
    logic [15:0] upper;
    an_e  = 4'hF;
    seg_e = 7'h7F;
    if (m_run) begin
      off  = m_pos % SLOT;
      slot = (m_pos / SLOT) % ND;
      if (off >= BC) begin
        an_e  = ~(4'b0001 << slot);
        upper = m_disp >> (4 * slot);
        if (!(m_bz && slot > 0 && upper == 16'h0)) seg_e = seg_tab[upper[3:0]];
      end
    end
  endfunction

  initial begin
    bit wrap;
    bit xfer;
    bit cap;
    forever begin
      @(posedge clk);
      m_bz = blank_zeros;
      if (!rst) begin
        m_started = 1;
        m_run  = 0;
        m_pos  = 0;
        m_fd   = 0;
        m_pv   = 0;
        m_disp = '0;
        m_pend = '0;
      end else begin
        wrap = m_run && enable && (m_pos % FRAME == FRAME - 1);
        xfer = m_pv && (!m_run || wrap);
        cap  = value_valid && !m_pv;
        if (xfer) begin
          m_disp = m_pend;
          m_pv   = 0;
        end else if (cap) begin
          m_pend = value_in;
          m_pv   = 1;
        end
        m_fd = wrap;
        if (!enable) begin
          m_run = 0;
          m_pos = 0;
        end else if (!m_run) begin
          m_run = 1;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
  end

  initial begin
    logic [3:0] a_e;
    logic [6:0] s_e;
    forever begin
      @(negedge clk);
      if (m_started) begin
        expect_out(a_e, s_e);
        check("an", 32'(an), 32'(a_e));
        check("seg", 32'(seg), 32'(s_e));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("value_ready", 32'(value_ready), 32'(!m_pv));
        check("dp", 32'(dp), 32'(1));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("d_rst_an", 32'(an), 32'hF);
    check("d_rst_seg", 32'(seg), 32'h7F);
    check("d_rst_dp", 32'(dp), 32'h1);
    check("d_rst_fd", 32'(frame_done), 32'h0);
    check("d_rst_ready", 32'(value_ready), 32'h1);

    // Load 12AF while idle, then start scanning.
    @(posedge clk); #1 value_in = 16'h12AF; value_valid = 1'b1;
    @(posedge clk); #1 value_valid = 1'b0;
    @(negedge clk);
    check("d_idle_busy", 32'(value_ready), 32'h0);
    @(posedge clk); #1 enable = 1'b1;
    repeat (3) @(posedge clk); @(negedge clk);
    check("d_dig0_an", 32'(an), 32'hE);
    check("d_dig0_seg", 32'(seg), 32'h0E);
    repeat (10) @(posedge clk); @(negedge clk);
    check("d_dig1_an", 32'(an), 32'hD);
    check("d_dig1_seg", 32'(seg), 32'h08);
    repeat (10) @(posedge clk); @(negedge clk);
    check("d_dig2_an", 32'(an), 32'hB);
    check("d_dig2_seg", 32'(seg), 32'h24);
    repeat (10) @(posedge clk); @(negedge clk);
    check("d_dig3_an", 32'(an), 32'h7);
    check("d_dig3_seg", 32'(seg), 32'h79);
    repeat (8) @(posedge clk); @(negedge clk);
    check("d_wrap_fd", 32'(frame_done), 32'h1);
    check("d_wrap_an", 32'(an), 32'hF);

    // Mid-frame load of 0005, with a second value (0000) held stalled behind it.
    @(posedge clk); #1 value_in = 16'h0005; value_valid = 1'b1;
    @(posedge clk); #1 value_in = 16'h0000;
    @(negedge clk);
    check("d_mid_ready", 32'(value_ready), 32'h0);
    check("d_mid_seg_old", 32'(seg), 32'h0E);
    repeat (40) @(posedge clk); @(negedge clk);
    check("d_new_an", 32'(an), 32'hE);
    check("d_new_seg", 32'(seg), 32'h12);
    check("d_second_held", 32'(value_ready), 32'h0);
    @(posedge clk); #1 value_valid = 1'b0; blank_zeros = 1'b1;

    // Leading-zero suppression on 0005, then 0000.
    repeat (9) @(posedge clk); @(negedge clk);
    check("d_bz1_an", 32'(an), 32'hD);
    check("d_bz1_seg", 32'(seg), 32'h7F);
    repeat (20) @(posedge clk); @(negedge clk);
    check("d_bz3_an", 32'(an), 32'h7);
    check("d_bz3_seg", 32'(seg), 32'h7F);
    repeat (10) @(posedge clk); @(negedge clk);
    check("d_zero0_an", 32'(an), 32'hE);
    check("d_zero0_seg", 32'(seg), 32'h40);
    repeat (10) @(posedge clk); @(negedge clk);
    check("d_zero1_an", 32'(an), 32'hD);
    check("d_zero1_seg", 32'(seg), 32'h7F);

    // Drop enable mid-SHOW, then restart.
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); @(negedge clk);
    check("d_dis_an", 32'(an), 32'hF);
    check("d_dis_seg", 32'(seg), 32'h7F);
    @(posedge clk); #1 enable = 1'b1;
    repeat (2) @(posedge clk); @(negedge clk);
    check("d_re_blank_an", 32'(an), 32'hF);
    @(posedge clk); @(negedge clk);
    check("d_re_show_an", 32'(an), 32'hE);
    check("d_re_show_seg", 32'(seg), 32'h40);

    // Reset mid-frame with a value pending.
    @(posedge clk); #1 value_in = 16'h7777; value_valid = 1'b1;
    @(posedge clk); #1 value_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("d_pend_ready", 32'(value_ready), 32'h0);
    @(posedge clk); @(negedge clk);
    check("d_rst2_an", 32'(an), 32'hF);
    check("d_rst2_seg", 32'(seg), 32'h7F);
    check("d_rst2_fd", 32'(frame_done), 32'h0);
    check("d_rst2_ready", 32'(value_ready), 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk); @(negedge clk);
    check("d_lost_an", 32'(an), 32'hE);
    check("d_lost_seg", 32'(seg), 32'h40);

    repeat (45) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
